// File: rtl/fpu_mm_sequencer.sv
// Command sequencer for the memory-mapped FPU slave: programs operands, starts
// the slave, polls done, reads the result and hands it back on a response port.
module fpu_mm_sequencer #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_sign_a,
    input  logic        cmd_sign_b,
    input  logic [7:0]  cmd_int_a,
    input  logic [7:0]  cmd_int_b,
    input  logic [7:0]  cmd_frac_a,
    input  logic [7:0]  cmd_frac_b,
    input  logic [1:0]  cmd_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic        avm_read,
    output logic [4:0]  avm_address,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [2:0] {IDLE, WRITE, POLL, READ_RES, RESP} state_t;

    localparam logic [4:0]  ADDR_START  = 5'h07;
    localparam logic [4:0]  ADDR_RESULT = 5'h08;
    localparam logic [4:0]  ADDR_DONE   = 5'h09;
    localparam logic [16:0] POLL_LAST   = 17'(TIMEOUT - 1);

    state_t      state;
    logic [3:0]  step;
    logic [16:0] poll_cnt;
    logic        sign_a_q, sign_b_q;
    logic [7:0]  int_a_q, int_b_q, frac_a_q, frac_b_q;
    logic [1:0]  op_q;

    // Address/data of write beat idx; beat 0 disarms start so beat 8 is a true rising edge.
    function automatic logic [36:0] write_beat(input logic [3:0] idx);
        logic [36:0] beat;
        case (idx)
            4'd0:    beat = {ADDR_START, 32'd0};
            4'd1:    beat = {5'h00, 31'd0, sign_a_q};
            4'd2:    beat = {5'h01, 24'd0, int_a_q};
            4'd3:    beat = {5'h02, 24'd0, frac_a_q};
            4'd4:    beat = {5'h03, 31'd0, sign_b_q};
            4'd5:    beat = {5'h04, 24'd0, int_b_q};
            4'd6:    beat = {5'h05, 24'd0, frac_b_q};
            4'd7:    beat = {5'h06, 30'd0, op_q};
            default: beat = {ADDR_START, 32'd1};
        endcase
        return beat;
    endfunction

    assign cmd_ready = (state == IDLE) && !reset;
    assign rsp_valid = (state == RESP) && !reset;
    assign busy      = (state != IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            step           <= 4'd0;
            poll_cnt       <= 17'd0;
            sign_a_q       <= 1'b0;
            sign_b_q       <= 1'b0;
            int_a_q        <= 8'd0;
            int_b_q        <= 8'd0;
            frac_a_q       <= 8'd0;
            frac_b_q       <= 8'd0;
            op_q           <= 2'd0;
            rsp_result     <= 32'd0;
            rsp_timeout    <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_address    <= 5'd0;
            avm_writedata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sign_a_q       <= cmd_sign_a;
                        sign_b_q       <= cmd_sign_b;
                        int_a_q        <= cmd_int_a;
                        int_b_q        <= cmd_int_b;
                        frac_a_q       <= cmd_frac_a;
                        frac_b_q       <= cmd_frac_b;
                        op_q           <= cmd_op;
                        step           <= 4'd0;
                        poll_cnt       <= 17'd0;
                        state          <= WRITE;
                        avm_chipselect <= 1'b1;
                        avm_write      <= 1'b1;
                        {avm_address, avm_writedata} <= write_beat(4'd0);
                    end
                end
                WRITE: begin
                    // Outputs are registered, so each cycle loads the beat shown next cycle.
                    if (step == 4'd8) begin
                        state         <= POLL;
                        avm_write     <= 1'b0;
                        avm_read      <= 1'b1;
                        avm_address   <= ADDR_DONE;
                        avm_writedata <= 32'd0;
                    end else begin
                        step <= step + 4'd1;
                        {avm_address, avm_writedata} <= write_beat(step + 4'd1);
                    end
                end
                POLL: begin
                    if (avm_readdata[0]) begin
                        state       <= READ_RES;
                        avm_address <= ADDR_RESULT;
                    end else if (poll_cnt == POLL_LAST) begin
                        state          <= RESP;
                        rsp_result     <= 32'd0;
                        rsp_timeout    <= 1'b1;
                        avm_chipselect <= 1'b0;
                        avm_read       <= 1'b0;
                        avm_address    <= 5'd0;
                    end else begin
                        poll_cnt <= poll_cnt + 17'd1;
                    end
                end
                READ_RES: begin
                    rsp_result     <= avm_readdata;
                    rsp_timeout    <= 1'b0;
                    state          <= RESP;
                    avm_chipselect <= 1'b0;
                    avm_read       <= 1'b0;
                    avm_address    <= 5'd0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mm_sequencer.sv
// Randomized scoreboard bench for fpu_mm_sequencer with a stub FPU slave.
module tb_fpu_mm_sequencer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic        cmd_sign_a, cmd_sign_b;
    logic [7:0]  cmd_int_a, cmd_int_b, cmd_frac_a, cmd_frac_b;
    logic [1:0]  cmd_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_timeout, busy;
    logic        avm_chipselect, avm_write, avm_read;
    logic [4:0]  avm_address;
    logic [31:0] avm_writedata, avm_readdata;

    fpu_mm_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sign_a(cmd_sign_a), .cmd_sign_b(cmd_sign_b),
        .cmd_int_a(cmd_int_a), .cmd_int_b(cmd_int_b),
        .cmd_frac_a(cmd_frac_a), .cmd_frac_b(cmd_frac_b),
        .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Stub slave: done reads 1 from poll index done_at onward; result register fixed per op.
    int          pend_done_at, stub_done_at, stub_poll;
    logic [31:0] pend_result, stub_result;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            stub_poll    <= 0;
            stub_done_at <= pend_done_at;
            stub_result  <= pend_result;
        end else if (avm_chipselect && avm_read && avm_address == 5'd9) begin
            stub_poll <= stub_poll + 1;
        end
    end

    always_comb begin
        avm_readdata = 32'd0;
        if (avm_chipselect && avm_read && avm_address == 5'd9)
            avm_readdata = {31'd0, (stub_poll >= stub_done_at)};
        else if (avm_chipselect && avm_read && avm_address == 5'd8)
            avm_readdata = stub_result;
    end

    typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
    typedef struct {logic [31:0] res; logic to; int vcyc; int polls;} rsp_t;
    wr_t  exp_wr[$];
    rsp_t exp_rsp[$];

    // Response consumer: 0 = random ready, 1 = tied high, 2 = hold low for hold_cnt RESP cycles.
    int rdy_mode = 1;
    int hold_cnt = 0;
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: rsp_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (rsp_valid && hold_cnt > 0) hold_cnt--;
                rsp_ready = (hold_cnt == 0);
            end
            default: rsp_ready = 1'b1;
        endcase
    end

    // Monitor
    int          mon_polls = 0;
    logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_to = 1'b0;
    logic [31:0] prev_res = 32'd0;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            chk("rw_exclusive", {63'd0, avm_write & avm_read}, 64'd0);
            if (avm_write) begin
                if (exp_wr.size() == 0) fail_now("unexpected_write");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", {59'd0, avm_address}, {59'd0, e.a});
                    chk("wr_data", {32'd0, avm_writedata}, {32'd0, e.d});
                    chk("wr_cs", {63'd0, avm_chipselect}, 64'd1);
                end
            end
            if (avm_chipselect && avm_read && avm_address == 5'd9) mon_polls++;
            if (cmd_valid && cmd_ready) mon_polls = 0;
            if (rsp_valid && !prev_valid) begin
                if (exp_rsp.size() == 0) fail_now("unexpected_response");
                else chk("rsp_latency", 64'(exp_rsp[0].vcyc), 64'(cyc));
            end
            if (rsp_valid && prev_valid && !prev_hs) begin
                chk("rsp_result_stable", {32'd0, rsp_result}, {32'd0, prev_res});
                chk("rsp_timeout_stable", {63'd0, rsp_timeout}, {63'd0, prev_to});
            end
            if (rsp_valid)
                chk("resp_quiet", {60'd0, cmd_ready, avm_chipselect, avm_write, avm_read}, 64'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) fail_now("unexpected_rsp_handshake");
                else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rsp_result", {32'd0, rsp_result}, {32'd0, r.res});
                    chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, r.to});
                    chk("poll_count", 64'(mon_polls), 64'(r.polls));
                end
            end
            prev_valid = rsp_valid;
            prev_hs    = rsp_valid & rsp_ready;
            prev_res   = rsp_result;
            prev_to    = rsp_timeout;
        end
    end

    task automatic randomize_cmd();
        cmd_sign_a = 1'($urandom);
        cmd_sign_b = 1'($urandom);
        cmd_int_a  = 8'($urandom);
        cmd_int_b  = 8'($urandom);
        cmd_frac_a = 8'($urandom);
        cmd_frac_b = 8'($urandom);
        cmd_op     = 2'($urandom);
    endtask

    // Issue one command; the reference expectation comes straight from the protocol rules.
    task automatic do_op(input logic sa, input logic [7:0] ia, input logic [7:0] fa,
                         input logic sb, input logic [7:0] ib, input logic [7:0] fb,
                         input logic [1:0] op, input int done_at, input logic [31:0] res,
                         output int hs);
        int   n;
        rsp_t r;
        pend_done_at = done_at;
        pend_result  = res;
        cmd_sign_a = sa; cmd_int_a = ia; cmd_frac_a = fa;
        cmd_sign_b = sb; cmd_int_b = ib; cmd_frac_b = fb;
        cmd_op = op;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 500);
        hs = cyc;
        if (!cmd_ready) begin
            fail_now("cmd_accept_timeout");
        end else begin
            exp_wr.push_back('{5'd7, 32'd0});
            exp_wr.push_back('{5'd0, {31'd0, sa}});
            exp_wr.push_back('{5'd1, {24'd0, ia}});
            exp_wr.push_back('{5'd2, {24'd0, fa}});
            exp_wr.push_back('{5'd3, {31'd0, sb}});
            exp_wr.push_back('{5'd4, {24'd0, ib}});
            exp_wr.push_back('{5'd5, {24'd0, fb}});
            exp_wr.push_back('{5'd6, {30'd0, op}});
            exp_wr.push_back('{5'd7, 32'd1});
            if (done_at < TO) begin
                r.res = res; r.to = 1'b0; r.vcyc = hs + 12 + done_at; r.polls = done_at + 1;
            end else begin
                r.res = 32'd0; r.to = 1'b1; r.vcyc = hs + 10 + TO; r.polls = TO;
            end
            exp_rsp.push_back(r);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        randomize_cmd();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_rsp.size() != 0) begin
            fail_now("response_wait_timeout");
            exp_rsp.delete();
            exp_wr.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs1, hs2;
        reset = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        randomize_cmd();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {19'd0, cmd_ready, rsp_valid, rsp_timeout, busy, avm_chipselect, avm_write,
             avm_read, avm_address, 32'd0},
            64'd0);
        chk("reset_result", {32'd0, rsp_result}, 64'd0);
        chk("reset_bus", {32'd0, avm_writedata}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);
        chk("idle_after_reset", {62'd0, busy, rsp_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Basic op: a = +3.5, b = -1.25, done at the 5th poll.
        rdy_mode = 1;
        do_op(1'b0, 8'h03, 8'h80, 1'b1, 8'h01, 8'h40, 2'd2, 4, 32'h12345678, hs1);
        wait_idle();
        // Immediate done
        do_op(1'b1, 8'hAA, 8'h55, 1'b0, 8'h0F, 8'hF0, 2'd1, 0, 32'hCAFEF00D, hs1);
        wait_idle();
        // Timeout: done never asserts
        do_op(1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 8'h44, 2'd3, 255, 32'hDEADBEEF, hs1);
        wait_idle();
        // Response backpressure
        rdy_mode = 2;
        hold_cnt = 20;
        do_op(1'b1, 8'h7E, 8'h01, 1'b1, 8'h80, 8'hFF, 2'd0, 2, 32'h0BADC0DE, hs1);
        wait_idle();
        // Back-to-back with rsp_ready tied high
        rdy_mode = 1;
        do_op(1'b0, 8'h01, 8'h02, 1'b1, 8'h03, 8'h04, 2'd1, 0, 32'h00000111, hs1);
        do_op(1'b1, 8'h05, 8'h06, 1'b0, 8'h07, 8'h08, 2'd2, 0, 32'h00000222, hs2);
        chk("b2b_gap", 64'(hs2 - hs1), 64'd13);
        wait_idle();

        // Reset while write step 4 is on the bus (cycle T+5)
        do_op(1'b1, 8'h99, 8'h88, 1'b1, 8'h77, 8'h66, 2'd3, 1, 32'h55AA55AA, hs1);
        repeat (4) @(posedge clk);
        #1;
        chk("step4_addr", {59'd0, avm_address}, 64'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_wr.delete();
        exp_rsp.delete();
        @(negedge clk);
        chk("abort_idle",
            {58'd0, avm_chipselect, avm_write, avm_read, busy, rsp_valid, cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        do_op(1'b0, 8'h12, 8'h34, 1'b1, 8'h56, 8'h78, 2'd1, 3, 32'hA5A5A5A5, hs1);
        wait_idle();

        // Randomized operations
        for (int i = 0; i < 25; i++) begin
            rdy_mode = $urandom_range(0, 1);
            do_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                  8'($urandom), 2'($urandom), $urandom_range(0, 10), $urandom, hs1);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        chk("writes_drained", 64'(exp_wr.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
